// File: rtl/l2_flush_ctrl_pkg.sv
// Shared definitions for the L2 flush controller: FSM state encoding and default widths.
package l2_flush_ctrl_pkg;

  localparam int unsigned L2F_CNT_BITS = 4;
  localparam int unsigned L2F_TMO_BITS = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAIN = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } l2_flush_ctrl_state_t;

endpackage

// File: rtl/l2_flush_ctrl_if.sv
// Handshake bundle between the flush controller, the config requester, the CPU path and the L2 core.
interface l2_flush_ctrl_if;

  logic flush_req_valid;
  logic flush_req_ready;
  logic flush_req_all;
  logic flush_resp_valid;
  logic flush_resp_ready;
  logic flush_resp_timeout;
  logic cpu_req_valid_in;
  logic cpu_req_ready_out;
  logic cpu_req_is_read;
  logic core_cpu_req_valid;
  logic core_cpu_req_ready;
  logic core_rd_rsp_valid;
  logic core_rd_rsp_ready;
  logic l2_flush_valid;
  logic l2_flush_i;
  logic l2_flush_ready;
  logic flush_done;

  modport master (
    input  flush_req_valid, flush_req_all,
    output flush_req_ready,
    output flush_resp_valid, flush_resp_timeout,
    input  flush_resp_ready,
    input  cpu_req_valid_in, cpu_req_is_read,
    output cpu_req_ready_out,
    output core_cpu_req_valid,
    input  core_cpu_req_ready,
    input  core_rd_rsp_valid, core_rd_rsp_ready,
    output l2_flush_valid, l2_flush_i,
    input  l2_flush_ready,
    input  flush_done
  );

  modport slave (
    output flush_req_valid, flush_req_all,
    input  flush_req_ready,
    input  flush_resp_valid, flush_resp_timeout,
    output flush_resp_ready,
    output cpu_req_valid_in, cpu_req_is_read,
    input  cpu_req_ready_out,
    input  core_cpu_req_valid,
    output core_cpu_req_ready,
    output core_rd_rsp_valid, core_rd_rsp_ready,
    input  l2_flush_valid, l2_flush_i,
    output l2_flush_ready,
    output flush_done
  );

endinterface

// File: rtl/l2_req_tracker.sv
// Outstanding-read up/down counter; reports full (no room for another read) and zero (drained).
module l2_req_tracker
  import l2_flush_ctrl_pkg::*;
#(
  parameter int unsigned CNT_BITS = L2F_CNT_BITS
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic zero
);

  localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

  logic [CNT_BITS-1:0] count_q;
  logic [CNT_BITS-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !dec) begin
      if (count_q != '1) count_d = count_q + CNT_ONE;
    end else if (dec && !inc) begin
      // A response with nothing outstanding is dropped rather than wrapping.
      if (count_q != '0) count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign full = (count_q == '1);
  assign zero = (count_q == '0);

  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(dec && !inc && zero));

endmodule

// File: rtl/l2_flush_ctrl.sv
// Whole-cache flush sequencer: drains CPU reads, issues the core flush, waits for done or timeout, responds.
module l2_flush_ctrl
  import l2_flush_ctrl_pkg::*;
#(
  parameter int unsigned CNT_BITS = L2F_CNT_BITS,
  parameter int unsigned TMO_BITS = L2F_TMO_BITS
) (
  input  logic                clk,
  input  logic                rst,
  l2_flush_ctrl_if.master     bus,
  input  logic [TMO_BITS-1:0] timeout_limit,
  output logic                busy
);

  localparam logic [TMO_BITS-1:0] TMO_ONE = {{(TMO_BITS-1){1'b0}}, 1'b1};
  localparam logic [TMO_BITS-1:0] TMO_MAX = '1;

  l2_flush_ctrl_state_t state_q, state_d;
  logic                 flush_all_q, flush_all_d;
  logic                 tmo_flag_q, tmo_flag_d;
  logic [TMO_BITS-1:0]  timer_q, timer_d;

  logic full_block;
  logic cnt_full;
  logic cnt_zero;
  logic rd_inc;
  logic rd_dec;
  logic tmo_hit;

  assign rd_inc  = bus.core_cpu_req_valid & bus.core_cpu_req_ready & bus.cpu_req_is_read;
  assign rd_dec  = bus.core_rd_rsp_valid & bus.core_rd_rsp_ready;
  assign tmo_hit = (timeout_limit != '0) && (timer_q == (timeout_limit - TMO_ONE));

  l2_req_tracker #(
    .CNT_BITS (CNT_BITS)
  ) u_tracker (
    .clk  (clk),
    .rst  (rst),
    .inc  (rd_inc),
    .dec  (rd_dec),
    .full (cnt_full),
    .zero (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      flush_all_q <= 1'b0;
      tmo_flag_q  <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      flush_all_q <= flush_all_d;
      tmo_flag_q  <= tmo_flag_d;
      timer_q     <= timer_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_all_d = flush_all_q;
    tmo_flag_d  = tmo_flag_q;
    timer_d     = timer_q;
    case (state_q)
      IDLE: begin
        if (bus.flush_req_valid) begin
          flush_all_d = bus.flush_req_all;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_zero) state_d = ISSUE;
      end
      ISSUE: begin
        if (bus.l2_flush_ready) begin
          timer_d = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (timer_q != TMO_MAX) timer_d = timer_q + TMO_ONE;
        // flush_done takes priority over a timeout landing in the same cycle.
        if (bus.flush_done) begin
          tmo_flag_d = 1'b0;
          state_d    = RESP;
        end else if (tmo_hit) begin
          tmo_flag_d = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (bus.flush_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    full_block             = bus.cpu_req_is_read & cnt_full;
    bus.flush_req_ready    = 1'b0;
    bus.core_cpu_req_valid = 1'b0;
    bus.cpu_req_ready_out  = 1'b0;
    bus.l2_flush_valid     = 1'b0;
    bus.l2_flush_i         = flush_all_q;
    bus.flush_resp_valid   = 1'b0;
    bus.flush_resp_timeout = tmo_flag_q;
    busy                   = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        bus.flush_req_ready    = 1'b1;
        bus.core_cpu_req_valid = bus.cpu_req_valid_in & ~full_block;
        bus.cpu_req_ready_out  = bus.core_cpu_req_ready & ~full_block;
      end
      ISSUE:   bus.l2_flush_valid   = 1'b1;
      RESP:    bus.flush_resp_valid = 1'b1;
      default: ;
    endcase
  end

  a_flush_hold: assert property (@(posedge clk) disable iff (rst)
    bus.l2_flush_valid && !bus.l2_flush_ready |=> bus.l2_flush_valid && $stable(bus.l2_flush_i));

  a_resp_hold: assert property (@(posedge clk) disable iff (rst)
    bus.flush_resp_valid && !bus.flush_resp_ready |=> bus.flush_resp_valid && $stable(bus.flush_resp_timeout));

endmodule

// File: tb/tb_l2_flush_ctrl.sv
// Directed bench for l2_flush_ctrl; a monitor scores flush issues and completions against queued expectations.
module tb_l2_flush_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] timeout_limit;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic exp_issue[$];
  logic exp_resp[$];

  l2_flush_ctrl_if bus ();

  l2_flush_ctrl #(
    .CNT_BITS (2),
    .TMO_BITS (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .timeout_limit (timeout_limit),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic wait_resp(input string name, input int unsigned max_cyc);
    int unsigned n;
    n = 0;
    mid();
    while (!bus.flush_resp_valid && n < max_cyc) begin
      cyc();
      mid();
      n++;
    end
    chk(name, bus.flush_resp_valid, 1'b1);
    cyc();
  endtask

  task automatic req_flush(input logic all, input logic exp_to);
    exp_issue.push_back(all);
    exp_resp.push_back(exp_to);
    bus.flush_req_valid = 1'b1;
    bus.flush_req_all   = all;
  endtask

  // Scoreboard: every core flush handshake and every completion handshake consumes one expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.l2_flush_valid && bus.l2_flush_ready) begin
        if (exp_issue.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL issue_unexpected: got flush issue, required none at %0t", $time);
        end else begin
          chk("issue_flush_all", bus.l2_flush_i, exp_issue.pop_front());
        end
      end
      if (bus.flush_resp_valid && bus.flush_resp_ready) begin
        if (exp_resp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected: got completion, required none at %0t", $time);
        end else begin
          chk("resp_timeout", bus.flush_resp_timeout, exp_resp.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    timeout_limit          = '0;
    bus.flush_req_valid    = 1'b0;
    bus.flush_req_all      = 1'b0;
    bus.flush_resp_ready   = 1'b1;
    bus.cpu_req_valid_in   = 1'b0;
    bus.cpu_req_is_read    = 1'b0;
    bus.core_cpu_req_ready = 1'b0;
    bus.core_rd_rsp_valid  = 1'b0;
    bus.core_rd_rsp_ready  = 1'b0;
    bus.l2_flush_ready     = 1'b0;
    bus.flush_done         = 1'b0;

    repeat (2) @(posedge clk);
    mid();
    chk("rst_flush_req_ready", bus.flush_req_ready, 1'b1);
    chk("rst_l2_flush_valid", bus.l2_flush_valid, 1'b0);
    chk("rst_flush_resp_valid", bus.flush_resp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    cyc();
    rst = 1'b0;

    // Idle gate passes a write straight through.
    bus.cpu_req_valid_in   = 1'b1;
    bus.core_cpu_req_ready = 1'b1;
    mid();
    chk("idle_core_valid", bus.core_cpu_req_valid, 1'b1);
    chk("idle_ready_out", bus.cpu_req_ready_out, 1'b1);
    cyc();
    bus.cpu_req_valid_in = 1'b0;

    // Plain flush-all with immediate core ready.
    bus.l2_flush_ready = 1'b1;
    req_flush(1'b1, 1'b0);
    mid();
    chk("t1_req_ready", bus.flush_req_ready, 1'b1);
    cyc();
    bus.flush_req_valid = 1'b0;
    bus.flush_req_all   = 1'b0;
    mid();
    chk("t1_busy_drain", busy, 1'b1);
    chk("t1_no_issue_in_drain", bus.l2_flush_valid, 1'b0);
    cyc();
    mid();
    chk("t1_issue_valid", bus.l2_flush_valid, 1'b1);
    chk("t1_issue_all", bus.l2_flush_i, 1'b1);
    cyc();
    mid();
    chk("t1_issue_one_cycle", bus.l2_flush_valid, 1'b0);
    repeat (4) cyc();
    bus.flush_done = 1'b1;
    cyc();
    bus.flush_done = 1'b0;
    mid();
    chk("t1_resp_after_done", bus.flush_resp_valid, 1'b1);
    chk("t1_resp_no_timeout", bus.flush_resp_timeout, 1'b0);
    cyc();
    mid();
    chk("t1_idle_after_resp", busy, 1'b0);

    // Three reads fill the 2-bit tracker; reads block, writes pass.
    cyc();
    bus.cpu_req_valid_in = 1'b1;
    bus.cpu_req_is_read  = 1'b1;
    mid();
    chk("t2_read_accepted", bus.cpu_req_ready_out, 1'b1);
    repeat (3) cyc();
    mid();
    chk("t2_full_read_ready", bus.cpu_req_ready_out, 1'b0);
    chk("t2_full_read_valid", bus.core_cpu_req_valid, 1'b0);
    bus.cpu_req_is_read = 1'b0;
    #1;
    chk("t2_full_write_valid", bus.core_cpu_req_valid, 1'b1);
    chk("t2_full_write_ready", bus.cpu_req_ready_out, 1'b1);
    cyc();
    bus.cpu_req_valid_in  = 1'b0;
    bus.core_rd_rsp_valid = 1'b1;
    bus.core_rd_rsp_ready = 1'b1;
    cyc();
    bus.cpu_req_valid_in = 1'b1;
    bus.cpu_req_is_read  = 1'b1;
    cyc();
    bus.core_rd_rsp_valid = 1'b0;
    mid();
    chk("t2_simul_inc_dec_held", bus.cpu_req_ready_out, 1'b1);
    cyc();
    mid();
    chk("t2_full_again", bus.cpu_req_ready_out, 1'b0);

    // Flush with three reads outstanding must wait for all three responses.
    bus.cpu_req_is_read = 1'b0;
    req_flush(1'b0, 1'b0);
    cyc();
    bus.flush_req_valid = 1'b0;
    mid();
    chk("t2_drain_ready_out", bus.cpu_req_ready_out, 1'b0);
    chk("t2_drain_core_valid", bus.core_cpu_req_valid, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      bus.core_rd_rsp_valid = 1'b1;
      cyc();
      bus.core_rd_rsp_valid = 1'b0;
      mid();
      chk("t2_drain_hold", bus.l2_flush_valid, 1'b0);
    end
    cyc();
    bus.cpu_req_valid_in = 1'b0;
    mid();
    chk("t2_issue_after_drain", bus.l2_flush_valid, 1'b1);
    cyc();
    cyc();
    bus.flush_done = 1'b1;
    cyc();
    bus.flush_done = 1'b0;
    wait_resp("t2_resp", 5);

    // Timeout after ten WAIT cycles, then a late done is ignored.
    timeout_limit = 16'd10;
    req_flush(1'b1, 1'b1);
    cyc();
    bus.flush_req_valid = 1'b0;
    repeat (11) cyc();
    mid();
    chk("t3_not_early", bus.flush_resp_valid, 1'b0);
    cyc();
    mid();
    chk("t3_tmo_resp", bus.flush_resp_valid, 1'b1);
    chk("t3_tmo_flag", bus.flush_resp_timeout, 1'b1);
    cyc();
    bus.flush_done = 1'b1;
    cyc();
    bus.flush_done = 1'b0;
    mid();
    chk("t3_late_done_busy", busy, 1'b0);
    chk("t3_late_done_resp", bus.flush_resp_valid, 1'b0);
    cyc();
    req_flush(1'b0, 1'b0);
    cyc();
    bus.flush_req_valid = 1'b0;
    repeat (3) cyc();
    bus.flush_done = 1'b1;
    cyc();
    bus.flush_done = 1'b0;
    wait_resp("t3_next_flush_resp", 4);

    // flush_done on the exact timeout cycle wins.
    req_flush(1'b1, 1'b0);
    cyc();
    bus.flush_req_valid = 1'b0;
    repeat (11) cyc();
    bus.flush_done = 1'b1;
    cyc();
    bus.flush_done = 1'b0;
    mid();
    chk("t4_coincide_resp", bus.flush_resp_valid, 1'b1);
    chk("t4_coincide_flag", bus.flush_resp_timeout, 1'b0);
    cyc();

    // Core holds off the flush for 20 cycles; request stays stable.
    timeout_limit      = '0;
    bus.l2_flush_ready = 1'b0;
    req_flush(1'b1, 1'b0);
    cyc();
    bus.flush_req_valid = 1'b0;
    bus.flush_req_all   = 1'b0;
    cyc();
    for (int k = 0; k < 20; k++) begin
      mid();
      chk("t5_hold_valid_and_all", bus.l2_flush_valid & bus.l2_flush_i, 1'b1);
      cyc();
    end
    bus.l2_flush_ready = 1'b1;
    cyc();
    repeat (2) cyc();
    bus.flush_done = 1'b1;
    cyc();
    bus.flush_done = 1'b0;
    wait_resp("t5_resp", 4);

    // Asynchronous reset in WAIT, then with reads outstanding.
    exp_issue.push_back(1'b0);
    bus.flush_req_valid = 1'b1;
    bus.flush_req_all   = 1'b0;
    cyc();
    bus.flush_req_valid = 1'b0;
    repeat (3) cyc();
    mid();
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_l2_flush_valid", bus.l2_flush_valid, 1'b0);
    chk("t6_rst_resp_valid", bus.flush_resp_valid, 1'b0);
    chk("t6_rst_req_ready", bus.flush_req_ready, 1'b1);
    bus.cpu_req_valid_in = 1'b1;
    bus.cpu_req_is_read  = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (3) cyc();
    mid();
    chk("t6_full_before_rst", bus.cpu_req_ready_out, 1'b0);
    rst = 1'b1;
    #1;
    chk("t6_rst_clears_count", bus.cpu_req_ready_out, 1'b1);
    bus.cpu_req_valid_in = 1'b0;
    cyc();
    rst = 1'b0;
    req_flush(1'b1, 1'b0);
    cyc();
    bus.flush_req_valid = 1'b0;
    cyc();
    mid();
    chk("t6_no_drain_after_rst", bus.l2_flush_valid, 1'b1);
    cyc();
    cyc();
    bus.flush_done = 1'b1;
    cyc();
    bus.flush_done = 1'b0;
    wait_resp("t6_resp", 4);

    mid();
    chk("issue_queue_empty", exp_issue.size() == 0, 1'b1);
    chk("resp_queue_empty", exp_resp.size() == 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
